// File: rtl/dispatch_pkg.sv
// Shared dispatch definitions: fuType width, int-complex fuType encodings and
// the port capability lookup used by the steering logic.
package dispatch_pkg;

    localparam int FU_W = 4;
    localparam int FU_N = 1 << FU_W;

    typedef enum logic [FU_W-1:0] {
        FU_MUL = 4'd4,
        FU_DIV = 4'd5,
        FU_ALU = 4'd6,
        FU_JMP = 4'd7
    } fu_type_e;

    function automatic logic fu_match(input logic [FU_N-1:0] mask, input logic [FU_W-1:0] fu);
        return mask[fu];
    endfunction

endpackage

// File: rtl/rs_port_reg.sv
// One-entry RS port output register: loads when a lane is steered here,
// otherwise drains on ready and holds its uop stable until taken.
module rs_port_reg #(
    parameter int FU_W      = 4,
    parameter int PAYLOAD_W = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 load,
    input  logic [FU_W-1:0]      load_fu,
    input  logic [PAYLOAD_W-1:0] load_payload,
    input  logic                 ready,
    output logic                 valid,
    output logic [FU_W-1:0]      fu,
    output logic [PAYLOAD_W-1:0] payload
);

    always_ff @(posedge clock) begin
        if (reset) begin
            valid   <= 1'b0;
            fu      <= '0;
            payload <= '0;
        end else begin
            // Flush wins over a same-cycle load so nothing survives a redirect.
            if (flush)      valid <= 1'b0;
            else if (load)  valid <= 1'b1;
            else if (ready) valid <= 1'b0;
            if (load && !flush) begin
                fu      <= load_fu;
                payload <= load_payload;
            end
        end
    end

endmodule

// File: rtl/dispatch2rs_buffered.sv
// In-order dispatch of IN_W lanes onto OUT_W capability-filtered RS ports,
// each backed by a one-entry output register, plus a blocked-cycle counter.
module dispatch2rs_buffered
    import dispatch_pkg::*;
#(
    parameter int IN_W      = 2,
    parameter int OUT_W     = 2,
    parameter int FU_W      = dispatch_pkg::FU_W,
    parameter int PAYLOAD_W = 64,
    parameter logic [OUT_W-1:0][(1<<FU_W)-1:0] PORT_FU_MASK = {16'h00F0, 16'h00F0}
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                io_redirect,
    input  logic [IN_W-1:0]                     io_in_valid,
    output logic [IN_W-1:0]                     io_in_ready,
    input  logic [IN_W-1:0][FU_W-1:0]           io_in_fuType,
    input  logic [IN_W-1:0][PAYLOAD_W-1:0]      io_in_payload,
    output logic [OUT_W-1:0]                    io_out_valid,
    input  logic [OUT_W-1:0]                    io_out_ready,
    output logic [OUT_W-1:0][PAYLOAD_W-1:0]     io_out_payload,
    output logic [OUT_W-1:0][FU_W-1:0]          io_out_fuType,
    output logic [31:0]                         io_perf_blocked
);

    logic [OUT_W-1:0]                port_free;
    logic [OUT_W-1:0]                load;
    logic [OUT_W-1:0][FU_W-1:0]      load_fu;
    logic [OUT_W-1:0][PAYLOAD_W-1:0] load_payload;
    logic [IN_W-1:0]                 ready;
    logic                            blocked;
    logic                            found;
    logic [31:0]                     perf_cnt;

    assign port_free = ~io_out_valid | io_out_ready;

    // load doubles as the claimed-port vector; only accepted lanes claim.
    always_comb begin
        load         = '0;
        load_fu      = '0;
        load_payload = '0;
        ready        = '0;
        blocked      = io_redirect;
        found        = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            found = 1'b0;
            for (int p = 0; p < OUT_W; p++) begin
                if (!found && port_free[p] && !load[p] &&
                    fu_match(PORT_FU_MASK[p], io_in_fuType[i])) begin
                    found = 1'b1;
                    if (io_in_valid[i] && !blocked) begin
                        load[p]         = 1'b1;
                        load_fu[p]      = io_in_fuType[i];
                        load_payload[p] = io_in_payload[i];
                    end
                end
            end
            ready[i] = found && !blocked;
            if (io_in_valid[i] && !ready[i]) blocked = 1'b1;
        end
    end

    assign io_in_ready = ready;

    for (genvar p = 0; p < OUT_W; p++) begin : g_port
        rs_port_reg #(
            .FU_W      (FU_W),
            .PAYLOAD_W (PAYLOAD_W)
        ) u_port (
            .clock        (clock),
            .reset        (reset),
            .flush        (io_redirect),
            .load         (load[p]),
            .load_fu      (load_fu[p]),
            .load_payload (load_payload[p]),
            .ready        (io_out_ready[p]),
            .valid        (io_out_valid[p]),
            .fu           (io_out_fuType[p]),
            .payload      (io_out_payload[p])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_cnt <= '0;
        end else if (io_in_valid[0] && !ready[0] && !io_redirect && perf_cnt != 32'hFFFF_FFFF) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign io_perf_blocked = perf_cnt;

endmodule

// File: tb/tb_dispatch2rs_buffered.sv
// Randomized and directed checks of dispatch2rs_buffered against a queue-based
// reference model of the steering, port-register and perf-counter rules.
module tb_dispatch2rs_buffered;

    localparam int IN_W = 2;
    localparam int OUT_W = 2;
    localparam int FU_W = 4;
    localparam int PW = 64;

    logic                         clock = 1'b0;
    logic                         reset;
    logic                         io_redirect;
    logic [IN_W-1:0]              io_in_valid;
    logic [IN_W-1:0]              io_in_ready;
    logic [IN_W-1:0][FU_W-1:0]    io_in_fuType;
    logic [IN_W-1:0][PW-1:0]      io_in_payload;
    logic [OUT_W-1:0]             io_out_valid;
    logic [OUT_W-1:0]             io_out_ready;
    logic [OUT_W-1:0][PW-1:0]     io_out_payload;
    logic [OUT_W-1:0][FU_W-1:0]   io_out_fuType;
    logic [31:0]                  io_perf_blocked;

    dispatch2rs_buffered dut (
        .clock           (clock),
        .reset           (reset),
        .io_redirect     (io_redirect),
        .io_in_valid     (io_in_valid),
        .io_in_ready     (io_in_ready),
        .io_in_fuType    (io_in_fuType),
        .io_in_payload   (io_in_payload),
        .io_out_valid    (io_out_valid),
        .io_out_ready    (io_out_ready),
        .io_out_payload  (io_out_payload),
        .io_out_fuType   (io_out_fuType),
        .io_perf_blocked (io_perf_blocked)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total = 0;

    // Reference model state
    logic [15:0]                  cap [OUT_W];
    logic [OUT_W-1:0]             mv;
    logic [OUT_W-1:0][FU_W-1:0]   mf;
    logic [OUT_W-1:0][PW-1:0]     mp;
    longint                       mperf;
    logic [IN_W-1:0]              erdy;
    int                           lane_port [IN_W];
    logic [OUT_W-1:0][PW-1:0]     held;

    // Apply inputs and derive the expected in_ready from the steering rules.
    task automatic drive(input logic [IN_W-1:0] v, input logic [3:0] f0, input logic [3:0] f1,
                         input logic [63:0] p0, input logic [63:0] p1,
                         input logic [OUT_W-1:0] ordy, input logic redir);
        int freeq[$];
        bit stop;
        int pick;
        io_in_valid = v;
        io_in_fuType[0] = f0;
        io_in_fuType[1] = f1;
        io_in_payload[0] = p0;
        io_in_payload[1] = p1;
        io_out_ready = ordy;
        io_redirect = redir;
        freeq = {};
        for (int p = 0; p < OUT_W; p++)
            if (!mv[p] || ordy[p]) freeq.push_back(p);
        stop = redir;
        erdy = '0;
        for (int i = 0; i < IN_W; i++) begin
            pick = -1;
            lane_port[i] = -1;
            for (int k = 0; k < freeq.size(); k++)
                if (pick < 0 && cap[freeq[k]][io_in_fuType[i]]) pick = k;
            erdy[i] = (pick >= 0) && !stop;
            if (v[i]) begin
                if (erdy[i]) begin
                    lane_port[i] = freeq[pick];
                    freeq.delete(pick);
                end else begin
                    stop = 1'b1;
                end
            end
        end
        #1;
    endtask

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic tick();
        for (int p = 0; p < OUT_W; p++)
            if (io_redirect || io_out_ready[p]) mv[p] = 1'b0;
        if (!io_redirect)
            for (int i = 0; i < IN_W; i++)
                if (io_in_valid[i] && erdy[i]) begin
                    mv[lane_port[i]] = 1'b1;
                    mf[lane_port[i]] = io_in_fuType[i];
                    mp[lane_port[i]] = io_in_payload[i];
                end
        if (io_in_valid[0] && !erdy[0] && !io_redirect && mperf < 64'hFFFF_FFFF) mperf++;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io_redirect = 1'b0;
        io_in_valid = '0;
        io_in_fuType = '0;
        io_in_payload = '0;
        io_out_ready = '1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        mv = '0; mf = '0; mp = '0; mperf = 0;
        total++; if (io_out_valid !== 2'b00) $display("FAIL reset_valid got=%b want=00", io_out_valid); else passed++;
        total++; if (io_out_payload !== '0 || io_out_fuType !== '0) $display("FAIL reset_data got=%h/%h want=0", io_out_payload, io_out_fuType); else passed++;
        total++; if (io_perf_blocked !== 32'd0) $display("FAIL reset_perf got=%0d want=0", io_perf_blocked); else passed++;
    endtask

    task automatic test_basic();
        drive(2'b11, 4'd6, 4'd4, 64'hA0, 64'hA1, 2'b11, 1'b0);
        total++; if (io_in_ready !== 2'b11) $display("FAIL basic_ready got=%b want=11", io_in_ready); else passed++;
        tick();
        total++; if (io_out_valid !== 2'b11) $display("FAIL basic_valid got=%b want=11", io_out_valid); else passed++;
        total++; if (io_out_fuType !== {4'd4, 4'd6}) $display("FAIL basic_fu got=%h want=46", io_out_fuType); else passed++;
        total++; if (io_out_payload !== {64'hA1, 64'hA0}) $display("FAIL basic_payload got=%h want=%h", io_out_payload, {64'hA1, 64'hA0}); else passed++;
    endtask

    task automatic test_unmatched();
        longint base;
        base = mperf;
        for (int c = 0; c < 3; c++) begin
            drive(2'b11, 4'd2, 4'd6, 64'hB0, 64'hB1, 2'b11, 1'b0);
            total++; if (io_in_ready !== 2'b00) $display("FAIL unmatched_ready got=%b want=00", io_in_ready); else passed++;
            tick();
        end
        total++; if (io_perf_blocked !== 32'(base + 3)) $display("FAIL unmatched_perf got=%0d want=%0d", io_perf_blocked, base + 3); else passed++;
        total++; if (io_out_valid !== 2'b00) $display("FAIL unmatched_valid got=%b want=00", io_out_valid); else passed++;
    endtask

    task automatic test_hold();
        drive(2'b01, 4'd6, 4'd6, 64'hC0, 64'hC1, 2'b00, 1'b0);
        tick();
        drive(2'b11, 4'd5, 4'd6, 64'hC2, 64'hC3, 2'b00, 1'b0);
        total++; if (io_in_ready !== 2'b01) $display("FAIL hold_ready got=%b want=01", io_in_ready); else passed++;
        tick();
        total++; if (io_out_valid !== 2'b11) $display("FAIL hold_valid got=%b want=11", io_out_valid); else passed++;
        total++; if (io_out_payload[0] !== 64'hC0 || io_out_payload[1] !== 64'hC2) $display("FAIL hold_payload got=%h want=%h", io_out_payload, {64'hC2, 64'hC0}); else passed++;
        total++; if (io_out_fuType[1] !== 4'd5) $display("FAIL hold_fu1 got=%0d want=5", io_out_fuType[1]); else passed++;
    endtask

    task automatic test_partial();
        drive(2'b11, 4'd6, 4'd7, 64'hD0, 64'hD1, 2'b01, 1'b0);
        total++; if (io_in_ready !== 2'b01) $display("FAIL partial_ready got=%b want=01", io_in_ready); else passed++;
        tick();
        total++; if (io_out_valid !== 2'b11) $display("FAIL partial_valid got=%b want=11", io_out_valid); else passed++;
        total++; if (io_out_payload !== {64'hC2, 64'hD0}) $display("FAIL partial_payload got=%h want=%h", io_out_payload, {64'hC2, 64'hD0}); else passed++;
    endtask

    task automatic test_redirect();
        drive(2'b11, 4'd6, 4'd7, 64'hE0, 64'hE1, 2'b11, 1'b1);
        total++; if (io_in_ready !== 2'b00) $display("FAIL redirect_ready got=%b want=00", io_in_ready); else passed++;
        tick();
        total++; if (io_out_valid !== 2'b00) $display("FAIL redirect_valid got=%b want=00", io_out_valid); else passed++;
        io_redirect = 1'b0;
    endtask

    task automatic test_saturate();
        force dut.perf_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.perf_cnt;
        mperf = 64'hFFFF_FFFD;
        for (int c = 0; c < 4; c++) begin
            drive(2'b01, 4'd3, 4'd6, 64'hF0, 64'hF1, 2'b11, 1'b0);
            tick();
            total++; if (io_perf_blocked !== 32'(mperf)) $display("FAIL sat_perf got=%h want=%h", io_perf_blocked, 32'(mperf)); else passed++;
        end
        total++; if (io_perf_blocked !== 32'hFFFF_FFFF) $display("FAIL sat_max got=%h want=ffffffff", io_perf_blocked); else passed++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(IN_W'($urandom), 4'($urandom_range(7, 4)), 4'($urandom_range(7, 4)),
                  {$urandom, $urandom}, {$urandom, $urandom}, OUT_W'($urandom),
                  ($urandom_range(15, 0) == 0));
            total++; if (io_in_ready !== erdy) $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, io_in_ready, erdy); else passed++;
            tick();
            total++; if (io_out_valid !== mv) $display("FAIL rand_valid cyc=%0d got=%b want=%b", c, io_out_valid, mv); else passed++;
            total++; if (io_out_fuType !== mf || io_out_payload !== mp) $display("FAIL rand_data cyc=%0d got=%h/%h want=%h/%h", c, io_out_fuType, io_out_payload, mf, mp); else passed++;
            total++; if (io_perf_blocked !== 32'(mperf)) $display("FAIL rand_perf cyc=%0d got=%0d want=%0d", c, io_perf_blocked, mperf); else passed++;
        end
    endtask

    task automatic test_mid_reset();
        drive(2'b11, 4'd4, 4'd5, 64'h11, 64'h22, 2'b00, 1'b0);
        tick();
        held = io_out_payload;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        mv = '0; mf = '0; mp = '0; mperf = 0;
        total++; if (io_out_valid !== 2'b00 || io_perf_blocked !== 32'd0) $display("FAIL midreset got=%b/%0d want=00/0", io_out_valid, io_perf_blocked); else passed++;
        total++; if (io_out_payload !== '0 || held === '0) $display("FAIL midreset_payload got=%h before=%h", io_out_payload, held); else passed++;
    endtask

    initial begin
        cap[0] = 16'h00F0;
        cap[1] = 16'h00F0;
        #2;
        test_reset();
        test_basic();
        test_unmatched();
        test_hold();
        test_partial();
        test_redirect();
        test_saturate();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
